// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the six-digit multiplexed seven-segment driver.
package seg_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;

  // Decimal points after minutes and seconds: mm.ss.ms
  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-high seven-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_disp.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot and freeze.
// Define SEG_LZ_BLANK_EN to blank a leading zero in the minute1 digit.
module seg_scan_disp
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLANK       = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic        clk_50Mhz,
  input  logic        rst,
  input  logic [23:0] dispbuf,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam digit_idx_t  LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic [PW-1:0] pcnt;
  digit_idx_t    idx;
  logic [23:0]   snap;

  logic          tick;
  logic          wrap;
  logic          load;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_act;
  logic          dp_act;
  logic [5:0]    dig_act;
  logic          lz_blank;

  assign tick = (pcnt == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == LAST_IDX);
  assign load = wrap && !freeze;

  bcd_to_seg7 u_dec (
    .bcd (nib),
    .seg (seg_dec)
  );

`ifdef SEG_LZ_BLANK_EN
  assign lz_blank = (idx == LAST_IDX) && (snap[23:20] == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    nib     = snap[{idx, 2'b00} +: 4];
    seg_act = lz_blank ? SEG_OFF : seg_dec;
    dp_act  = !lz_blank && (|(DP_MASK & (6'b000001 << idx)));
    dig_act = (pcnt < PW'(BLANK)) ? 6'b000000 : (6'b000001 << idx);
  end

  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      pcnt       <= '0;
      idx        <= LAST_IDX;
      snap       <= '0;
      seg        <= {7{SEG_ACT_LOW}};
      dp         <= SEG_ACT_LOW;
      dig_sel    <= {6{DIG_ACT_LOW}};
      frame_done <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) begin
        idx <= wrap ? '0 : idx + digit_idx_t'(1);
      end
      if (load) begin
        snap <= dispbuf;
      end
      frame_done <= load;
      // Outputs reflect this cycle's pcnt/idx/snap, one cycle later
      seg     <= seg_act ^ {7{SEG_ACT_LOW}};
      dp      <= dp_act ^ SEG_ACT_LOW;
      dig_sel <= dig_act ^ {6{DIG_ACT_LOW}};
    end
  end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Directed bench for seg_scan_disp at SCAN_DIV=8, BLANK=2, active-low outputs.
module tb_seg_scan_disp;

  logic        clk_50Mhz = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] dispbuf = '0;
  logic        freeze = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig_sel;
  logic        frame_done;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [6:0] cs [48];
  logic       cd [48];
  logic [5:0] cg [48];

  seg_scan_disp #(
    .SCAN_DIV    (8),
    .BLANK       (2),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk_50Mhz  (clk_50Mhz),
    .rst        (rst),
    .dispbuf    (dispbuf),
    .freeze     (freeze),
    .seg        (seg),
    .dp         (dp),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  // Expected active-low segment pattern for a nibble
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
      4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
      4'd8: p = 7'h7F;  4'd9: p = 7'h6F;  default: p = 7'h40;
    endcase
    return ~p;
  endfunction

  task automatic wait_frame(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50Mhz);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: frame_done not seen within %0d cycles", limit);
    end
  endtask

  // Sample s corresponds to slot s/8, pcnt s%8 of the frame just loaded
  task automatic capture(input int change_at, input logic [23:0] nb);
    for (int s = 0; s < 48; s++) begin
      @(negedge clk_50Mhz);
      cs[s] = seg;
      cd[s] = dp;
      cg[s] = dig_sel;
      if (s == change_at) dispbuf = nb;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk_50Mhz);
    vectors++;
    if (seg !== 7'h7F || dig_sel !== 6'h3F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: seg=%h dig_sel=%h dp=%b fd=%b, want 7f 3f 1 0",
               seg, dig_sel, dp, frame_done);
    end
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50Mhz);
      n++;
      if (frame_done === 1'b1) break;
    end
    vectors++;
    if (n != 8) begin
      errors++;
      $display("FAIL first_frame_done: after %0d cycles, want 8", n);
    end
  endtask

  task automatic test_basic_scan;
    logic [23:0] v;
    int lows;
    v = 24'h123456;
    dispbuf = v;
    wait_frame(100);
    capture(-1, '0);
    for (int d = 0; d < 6; d++) begin
      vectors++;
      if (cs[d*8+4] !== exp_seg(v[d*4 +: 4])) begin
        errors++;
        $display("FAIL basic_seg d%0d: got %h want %h", d, cs[d*8+4], exp_seg(v[d*4 +: 4]));
      end
      vectors++;
      if (cd[d*8+4] !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL basic_dp d%0d: got %b", d, cd[d*8+4]);
      end
      vectors++;
      if (cg[d*8+1] !== 6'h3F || cg[d*8+4] !== ~(6'b000001 << d)) begin
        errors++;
        $display("FAIL basic_digsel d%0d: blank=%h active=%h want 3f %h",
                 d, cg[d*8+1], cg[d*8+4], ~(6'b000001 << d));
      end
      lows = 0;
      for (int s = 0; s < 48; s++) if (cg[s][d] === 1'b0) lows++;
      vectors++;
      if (lows != 6) begin
        errors++;
        $display("FAIL basic_dig_width d%0d: low for %0d cycles, want 6", d, lows);
      end
    end
  endtask

  task automatic test_snapshot_integrity;
    dispbuf = 24'h000000;
    wait_frame(100);
    capture(19, 24'h595999);
    for (int d = 0; d < 6; d++) begin
      vectors++;
      if (cs[d*8+6] !== ~7'h3F) begin
        errors++;
        $display("FAIL integrity_old d%0d: got %h want %h", d, cs[d*8+6], ~7'h3F);
      end
    end
    capture(-1, '0);
    vectors++;
    if (cs[4] !== exp_seg(4'h9) || cs[12] !== exp_seg(4'h9) || cs[20] !== exp_seg(4'h9) ||
        cs[28] !== exp_seg(4'h5) || cs[36] !== exp_seg(4'h9) || cs[44] !== exp_seg(4'h5)) begin
      errors++;
      $display("FAIL integrity_new: d0=%h d3=%h d5=%h, want %h %h %h",
               cs[4], cs[28], cs[44], exp_seg(4'h9), exp_seg(4'h5), exp_seg(4'h5));
    end
  endtask

  task automatic test_freeze;
    int fd_cnt;
    dispbuf = 24'h111111;
    wait_frame(100);
    freeze  = 1'b1;
    dispbuf = 24'h222222;
    fd_cnt  = 0;
    for (int s = 0; s < 96; s++) begin
      @(negedge clk_50Mhz);
      if (frame_done === 1'b1) fd_cnt++;
      if (s == 4 || s == 52) begin
        vectors++;
        if (seg !== exp_seg(4'h1)) begin
          errors++;
          $display("FAIL freeze_hold s%0d: got %h want %h", s, seg, exp_seg(4'h1));
        end
      end
    end
    vectors++;
    if (fd_cnt != 0) begin
      errors++;
      $display("FAIL freeze_frame_done: %0d pulses, want 0", fd_cnt);
    end
    freeze = 1'b0;
    wait_frame(100);
    capture(-1, '0);
    vectors++;
    if (cs[4] !== exp_seg(4'h2)) begin
      errors++;
      $display("FAIL freeze_resume: got %h want %h", cs[4], exp_seg(4'h2));
    end
  endtask

  task automatic test_invalid_bcd;
    dispbuf = 24'hA00000;
    wait_frame(100);
    capture(-1, '0);
    vectors++;
    if (cs[44] !== ~7'h40) begin
      errors++;
      $display("FAIL invalid_dash: got %h want %h", cs[44], ~7'h40);
    end
    vectors++;
    if (cs[36] !== ~7'h3F) begin
      errors++;
      $display("FAIL invalid_neighbour: got %h want %h", cs[36], ~7'h3F);
    end
  endtask

  task automatic test_leading_zero;
    logic [6:0] want_seg;
    logic       want_dp;
`ifdef SEG_LZ_BLANK_EN
    want_seg = 7'h7F;
`else
    want_seg = ~7'h3F;
`endif
    want_dp = 1'b1;
    dispbuf = 24'h012345;
    wait_frame(100);
    capture(-1, '0);
    vectors++;
    if (cs[44] !== want_seg || cd[44] !== want_dp) begin
      errors++;
      $display("FAIL lz_digit5: seg=%h dp=%b want %h %b", cs[44], cd[44], want_seg, want_dp);
    end
    vectors++;
    if (cg[44] !== 6'b011111) begin
      errors++;
      $display("FAIL lz_digsel: got %h want 1f", cg[44]);
    end
    vectors++;
    if (cs[36] !== exp_seg(4'h1)) begin
      errors++;
      $display("FAIL lz_digit4: got %h want %h", cs[36], exp_seg(4'h1));
    end
  endtask

  task automatic test_async_reset;
    repeat (13) @(negedge clk_50Mhz);
    rst = 1'b0;
    #1;
    vectors++;
    if (seg !== 7'h7F || dig_sel !== 6'h3F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: seg=%h dig_sel=%h dp=%b fd=%b, want 7f 3f 1 0",
               seg, dig_sel, dp, frame_done);
    end
    @(negedge clk_50Mhz);
    rst = 1'b1;
    repeat (2) @(negedge clk_50Mhz);
  endtask

  initial begin
    test_reset;
    test_basic_scan;
    test_snapshot_integrity;
    test_freeze;
    test_invalid_bcd;
    test_leading_zero;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
